// File: rtl/regfile_operand_stage.sv
// Integer register file with same-cycle writeback bypass, feeding the ID/EX operand stage
// register that holds the R-type operand pair, destination and operation selects for execute.
module regfile_operand_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_func3,
  input  logic            id_bit_th,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_operator1,
  output logic [XLEN-1:0] ex_operator2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_func3,
  output logic            ex_bit_th
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wb_write;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;

  assign wb_write = wb_en && (wb_rd != 5'd0);

  // Register file writes proceed regardless of stall/flush; only reset blocks them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_write) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (id_rs1 != 5'd0) begin
      rdata1 = regs_q[id_rs1];
    end
    if (id_rs2 != 5'd0) begin
      rdata2 = regs_q[id_rs2];
    end
    if (wb_write && (wb_rd == id_rs1)) begin
      rdata1 = wb_data;
    end
    if (wb_write && (wb_rd == id_rs2)) begin
      rdata2 = wb_data;
    end
  end

  // Held operands are not refreshed by writebacks during a stall; the hazard unit covers that.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      ex_valid     <= 1'b0;
      ex_operator1 <= '0;
      ex_operator2 <= '0;
      ex_rd        <= '0;
      ex_func3     <= '0;
      ex_bit_th    <= 1'b0;
    end else if (!stall) begin
      ex_valid     <= id_valid;
      ex_operator1 <= rdata1;
      ex_operator2 <= rdata2;
      ex_rd        <= id_rd;
      ex_func3     <= id_func3;
      ex_bit_th    <= id_bit_th;
    end
  end

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Directed self-checking bench for regfile_operand_stage: reset, write/read, bypass, x0,
// stall/flush and mid-operation reset scenarios.
module tb_regfile_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_func3;
  logic        id_bit_th;
  logic        stall, flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_operator1, ex_operator2;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_func3;
  logic        ex_bit_th;

  int errors = 0;
  int checks = 0;

  regfile_operand_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_func3(id_func3), .id_bit_th(id_bit_th), .stall(stall), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid),
    .ex_operator1(ex_operator1), .ex_operator2(ex_operator2), .ex_rd(ex_rd),
    .ex_func3(ex_func3), .ex_bit_th(ex_bit_th)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [2:0] f3, input logic bt);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_func3 = f3; id_bit_th = bt;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
    wb_en = en; wb_rd = rd; wb_data = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 3'd4, 1'b1);
    set_wb(1'b0, 5'd0, 32'h0);
    step(); step();
    checks++;
    if ({ex_valid, ex_rd, ex_func3, ex_bit_th} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0", {ex_valid, ex_rd, ex_func3, ex_bit_th});
    end
    checks++;
    if (ex_operator1 !== 32'h0 || ex_operator2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_ops: got %h %h required 0 0", ex_operator1, ex_operator2);
    end
    rst_n = 1'b1;
    set_id(1'b1, 5'd5, 5'd31, 5'd1, 3'd0, 1'b0);
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_operator1 !== 32'h0 || ex_operator2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_read: got v=%b %h %h required v=1 0 0",
               ex_valid, ex_operator1, ex_operator2);
    end
  endtask

  task automatic test_write_read();
    set_id(1'b0, 5'd1, 5'd2, 5'd6, 3'd1, 1'b0);
    set_wb(1'b1, 5'd7, 32'hDEADBEEF);
    step();
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL idvalid_low: got ex_valid=%b required 0", ex_valid);
    end
    set_wb(1'b0, 5'd0, 32'h0);
    set_id(1'b1, 5'd7, 5'd0, 5'd2, 3'b000, 1'b1);
    step();
    checks++;
    if (ex_operator1 !== 32'hDEADBEEF || ex_operator2 !== 32'h0) begin
      errors++;
      $display("FAIL write_read_ops: got %h %h required deadbeef 0", ex_operator1, ex_operator2);
    end
    checks++;
    if (ex_func3 !== 3'd0 || ex_bit_th !== 1'b1 || ex_rd !== 5'd2 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL write_read_ctrl: got f3=%0d bt=%b rd=%0d v=%b required 0 1 2 1",
               ex_func3, ex_bit_th, ex_rd, ex_valid);
    end
  endtask

  task automatic test_bypass();
    set_wb(1'b1, 5'd3, 32'h80000000);
    set_id(1'b1, 5'd3, 5'd3, 5'd4, 3'd6, 1'b0);
    step();
    checks++;
    if (ex_operator1 !== 32'h80000000 || ex_operator2 !== 32'h80000000) begin
      errors++;
      $display("FAIL bypass_both: got %h %h required 80000000 80000000",
               ex_operator1, ex_operator2);
    end
    // Bypass on rs2 only; rs1 reads the array value written two cycles back.
    set_wb(1'b1, 5'd12, 32'h0000_1234);
    set_id(1'b1, 5'd7, 5'd12, 5'd4, 3'd6, 1'b0);
    step();
    checks++;
    if (ex_operator1 !== 32'hDEADBEEF || ex_operator2 !== 32'h0000_1234) begin
      errors++;
      $display("FAIL bypass_rs2: got %h %h required deadbeef 00001234",
               ex_operator1, ex_operator2);
    end
  endtask

  task automatic test_x0();
    set_wb(1'b1, 5'd0, 32'hFFFFFFFF);
    set_id(1'b1, 5'd0, 5'd3, 5'd5, 3'd2, 1'b0);
    step();
    checks++;
    if (ex_operator1 !== 32'h0 || ex_operator2 !== 32'h80000000) begin
      errors++;
      $display("FAIL x0_same_cycle: got %h %h required 0 80000000", ex_operator1, ex_operator2);
    end
    set_wb(1'b0, 5'd0, 32'h0);
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 3'd2, 1'b0);
    step();
    checks++;
    if (ex_operator1 !== 32'h0 || ex_operator2 !== 32'h0) begin
      errors++;
      $display("FAIL x0_next_cycle: got %h %h required 0 0", ex_operator1, ex_operator2);
    end
  endtask

  task automatic test_stall_flush();
    set_id(1'b1, 5'd7, 5'd3, 5'd9, 3'd5, 1'b0);
    step();
    checks++;
    if (ex_rd !== 5'd9 || ex_operator1 !== 32'hDEADBEEF || ex_func3 !== 3'd5) begin
      errors++;
      $display("FAIL stall_load: got rd=%0d %h f3=%0d required 9 deadbeef 5",
               ex_rd, ex_operator1, ex_func3);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b0, 5'd3 + 5'(i), 5'd7, 5'd20 + 5'(i), 3'(i), 1'b1);
      set_wb(1'b1, 5'd7, 32'h12345670 + 32'(i));
      step();
      checks++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_func3 !== 3'd5 || ex_bit_th !== 1'b0 ||
          ex_operator1 !== 32'hDEADBEEF || ex_operator2 !== 32'h80000000) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b rd=%0d f3=%0d bt=%b %h %h required 1 9 5 0 deadbeef 80000000",
                 i, ex_valid, ex_rd, ex_func3, ex_bit_th, ex_operator1, ex_operator2);
      end
    end
    stall = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    set_id(1'b1, 5'd7, 5'd0, 5'd9, 3'd5, 1'b0);
    step();
    checks++;
    if (ex_operator1 !== 32'h12345672) begin
      errors++;
      $display("FAIL stall_wb_written: got %h required 12345672", ex_operator1);
    end
    stall = 1'b1; flush = 1'b1;
    step();
    checks++;
    if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_operator1 !== 32'h0 || ex_func3 !== 3'd0) begin
      errors++;
      $display("FAIL stall_flush: got v=%b rd=%0d %h f3=%0d required 0 0 0 0",
               ex_valid, ex_rd, ex_operator1, ex_func3);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_id(1'b1, 5'd7, 5'd3, 5'd11, 3'd7, 1'b1);
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_operator2 !== 32'h80000000) begin
      errors++;
      $display("FAIL premid_load: got v=%b %h required 1 80000000", ex_valid, ex_operator2);
    end
    rst_n = 1'b0;
    set_wb(1'b1, 5'd4, 32'hAAAA5555);
    step();
    checks++;
    if ({ex_valid, ex_rd, ex_func3, ex_bit_th} !== 10'b0 ||
        ex_operator1 !== 32'h0 || ex_operator2 !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outs: got v=%b rd=%0d %h %h required all 0",
               ex_valid, ex_rd, ex_operator1, ex_operator2);
    end
    rst_n = 1'b1;
    set_wb(1'b0, 5'd0, 32'h0);
    set_id(1'b1, 5'd7, 5'd3, 5'd1, 3'd0, 1'b0);
    step();
    checks++;
    if (ex_operator1 !== 32'h0 || ex_operator2 !== 32'h0 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_cleared: got v=%b %h %h required 1 0 0",
               ex_valid, ex_operator1, ex_operator2);
    end
    set_id(1'b1, 5'd4, 5'd12, 5'd1, 3'd0, 1'b0);
    step();
    checks++;
    if (ex_operator1 !== 32'h0 || ex_operator2 !== 32'h0) begin
      errors++;
      $display("FAIL midreset_wb_ignored: got %h %h required 0 0", ex_operator1, ex_operator2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_stall_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
